snake_dir_input: RTL

- Conditions the four raw direction push-buttons before they reach the snake game core: synchronise, debounce, edge-detect, arbitrate.
- Drops illegal reversals.
- Holds one pending direction request and commits it on the game-step strobe.
- Drives level one-hot up/down/left/right into the snake core's direction inputs, so the core sees exactly one clean, legal direction per game step.

---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_dir_input_btn_debounce.sv | 47 ++++
 rtl/snake_dir_input.sv | 128 ++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake direction input path.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int unsigned DEBOUNCE_DEFAULT = 32'd50_000;
  localparam int unsigned CNT_W_DEFAULT    = 32'd16;

  // Reversal partner: flipping the low bit pairs UP/DOWN and LEFT/RIGHT.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

  // Returns {up, down, left, right}.
  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    logic [3:0] oh;
    case (d)
      DIR_UP:    oh = 4'b1000;
      DIR_DOWN:  oh = 4'b0100;
      DIR_LEFT:  oh = 4'b0010;
      DIR_RIGHT: oh = 4'b0001;
      default:   oh = 4'b0001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/snake_dir_input_btn_debounce.sv
// One push-button conditioner: 2-FF synchroniser, restartable debounce counter,
// accepted level and a one-cycle rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd50_000,
  parameter int unsigned CNT_W           = 32'd16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic             stable_d_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise, debounce and delay the accepted level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      cnt_r      <= '0;
    end else begin
      sync1_r    <= btn;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      if (sync2_r != stable_r) begin
        if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 32'd1)) begin
          stable_r <= sync2_r;
          cnt_r    <= '0;
        end else begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        // Any agreement with the accepted level restarts the count.
        cnt_r <= '0;
      end
    end
  end

  assign press = stable_r & ~stable_d_r;

endmodule

// File: rtl/snake_dir_input.sv
// Turns four raw direction buttons into one clean, legal, one-hot direction
// that only changes on the snake core's game-step strobe.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       step_tick,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [1:0] dir,
  output logic       dir_changed
);

  // Bit index equals the direction code, so the winner's index is its code.
  logic [3:0] btn_raw_s;
  logic [3:0] press_s;

  logic [1:0] dir_r;
  logic [3:0] onehot_r;
  logic [1:0] pending_r;
  logic       pending_valid_r;
  logic       dir_changed_r;

  logic       req_valid_s;
  logic [1:0] req_dir_s;
  logic       req_legal_s;
  logic       pending_legal_s;
  logic [1:0] dir_next_s;
  logic [1:0] pending_next_s;
  logic       pending_valid_next_s;
  logic       commit_s;

  assign btn_raw_s = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn (
      .clk  (clk),
      .reset(reset),
      .btn  (btn_raw_s[i]),
      .press(press_s[i])
    );
  end

  // Fixed-priority arbitration of same-cycle presses: up > down > left > right.
  always_comb begin
    req_valid_s = 1'b0;
    req_dir_s   = DIR_UP;
    if (press_s[0]) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_UP;
    end else if (press_s[1]) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_DOWN;
    end else if (press_s[2]) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_LEFT;
    end else if (press_s[3]) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_RIGHT;
    end else begin
      req_valid_s = 1'b0;
      req_dir_s   = DIR_UP;
    end
  end

  assign req_legal_s     = req_valid_s && (req_dir_s != dir_r) && (req_dir_s != opposite(dir_r));
  assign pending_legal_s = (pending_r != dir_r) && (pending_r != opposite(dir_r));

  // Capture into the pending slot between ticks; commit at most once per tick.
  always_comb begin
    dir_next_s           = dir_r;
    pending_next_s       = pending_r;
    pending_valid_next_s = pending_valid_r;
    commit_s             = 1'b0;
    if (step_tick) begin
      pending_valid_next_s = 1'b0;
      if (req_legal_s) begin
        dir_next_s = req_dir_s;
        commit_s   = 1'b1;
      end else if (pending_valid_r && pending_legal_s) begin
        dir_next_s = pending_r;
        commit_s   = 1'b1;
      end else begin
        commit_s = 1'b0;
      end
    end else if (req_legal_s) begin
      pending_next_s       = req_dir_s;
      pending_valid_next_s = 1'b1;
    end else begin
      pending_valid_next_s = pending_valid_r;
    end
  end

  // Direction state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_r           <= DIR_RIGHT;
      onehot_r        <= 4'b0001;
      pending_r       <= DIR_UP;
      pending_valid_r <= 1'b0;
      dir_changed_r   <= 1'b0;
    end else begin
      dir_r           <= dir_next_s;
      onehot_r        <= dir_onehot(dir_next_s);
      pending_r       <= pending_next_s;
      pending_valid_r <= pending_valid_next_s;
      dir_changed_r   <= commit_s;
    end
  end

  assign {up, down, left, right} = onehot_r;
  assign dir         = dir_r;
  assign dir_changed = dir_changed_r;

endmodule
